// File: rtl/stream_mux_pkg.sv
// Shared encodings for the round-robin stream multiplexer.
package stream_mux_pkg;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Rotate-priority search: first requester at or after ptr, wrapping at N_CH.
module rr_arbiter #(
    parameter int N_CH  = 4,
    parameter int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    always_comb begin
        int idx;
        idx       = 0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            idx = (int'(ptr) + k) % N_CH;
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel registered stream mux with fixed/round-robin arbitration and
// packet locking on in_last.
//
// state   | meaning
// ST_ARB  | between packets; grant chosen by mode (sel or round-robin)
// ST_LOCK | mid-packet; only lock_ch may send until its last beat
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic [N_CH-1:0]          in_valid,
    input  logic [N_CH-1:0]          in_last,
    output logic [N_CH-1:0]          in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_valid,
    input  logic                     out_ready
);

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    lock_ch_q, lock_ch_d;
    logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_last_q, out_last_d;
    logic [SEL_W-1:0]    out_ch_q, out_ch_d;
    logic                out_valid_q, out_valid_d;

    logic [SEL_W-1:0]    rr_gnt_idx;
    logic                rr_gnt_valid;
    logic [SEL_W-1:0]    grant;
    logic                grant_valid;
    logic [DATA_W-1:0]   grant_data;
    logic                grant_last;
    logic                load_en;
    logic                accept;

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_rr_arbiter (
        .req       (in_valid),
        .ptr       (rr_ptr_q),
        .gnt_idx   (rr_gnt_idx),
        .gnt_valid (rr_gnt_valid)
    );

    // An out-of-range sel matches no channel, so it simply never grants.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        if (state_q == ST_LOCK) begin
            grant = lock_ch_q;
            for (int i = 0; i < N_CH; i++)
                if (lock_ch_q == SEL_W'(i)) grant_valid = in_valid[i];
        end else if (mode == MODE_RR) begin
            grant       = rr_gnt_idx;
            grant_valid = rr_gnt_valid;
        end else begin
            grant = sel;
            for (int i = 0; i < N_CH; i++)
                if (sel == SEL_W'(i)) grant_valid = in_valid[i];
        end
    end

    always_comb begin
        grant_data = '0;
        grant_last = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant == SEL_W'(i)) begin
                grant_data = in_data[i*DATA_W +: DATA_W];
                grant_last = in_last[i];
            end
        end
    end

    assign load_en = !out_valid_q || out_ready;
    assign accept  = load_en && grant_valid;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N_CH; i++)
            in_ready[i] = !rst && accept && (grant == SEL_W'(i));
    end

    always_comb begin
        state_d     = state_q;
        lock_ch_d   = lock_ch_q;
        rr_ptr_d    = rr_ptr_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_data_d  = grant_data;
            out_last_d  = grant_last;
            out_ch_d    = grant;
            out_valid_d = 1'b1;
            if (state_q == ST_ARB && !grant_last) begin
                state_d   = ST_LOCK;
                lock_ch_d = grant;
            end else if (state_q == ST_LOCK && grant_last) begin
                state_d = ST_ARB;
            end
            if (grant_last)
                rr_ptr_d = (grant == SEL_W'(N_CH - 1)) ? '0 : grant + SEL_W'(1);
        end else if (load_en) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ARB;
            lock_ch_q   <= '0;
            rr_ptr_q    <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_ch_q   <= lock_ch_d;
            rr_ptr_q    <= rr_ptr_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a 4-channel instance for most scenarios
// and a 3-channel instance for the out-of-range select case.
module tb_stream_mux_rr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        mode;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid, in_last, in_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic [1:0]  out_ch;
    logic        out_valid, out_ready;

    logic        mode3;
    logic [1:0]  sel3;
    logic [23:0] in_data3;
    logic [2:0]  in_valid3, in_last3, in_ready3;
    logic [7:0]  out_data3;
    logic        out_last3;
    logic [1:0]  out_ch3;
    logic        out_valid3, out_ready3;

    int n_pass  = 0;
    int n_total = 0;
    int n_in    = 0;
    int n_out   = 0;
    logic [7:0] xz_pat;

    stream_mux_rr #(.N_CH(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_last(out_last), .out_ch(out_ch),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    stream_mux_rr #(.N_CH(3), .DATA_W(8)) dut3 (
        .clk(clk), .rst(rst), .mode(mode3), .sel(sel3),
        .in_data(in_data3), .in_valid(in_valid3), .in_last(in_last3), .in_ready(in_ready3),
        .out_data(out_data3), .out_last(out_last3), .out_ch(out_ch3),
        .out_valid(out_valid3), .out_ready(out_ready3)
    );

    // Inputs only change just after posedge, so negedge values are what the next edge samples.
    always @(negedge clk) begin
        if (!rst) begin
            if ((in_valid & in_ready) != 4'b0000) n_in++;
            if (out_valid && out_ready) n_out++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    initial begin
        mode = 1'b0; sel = 2'd0; out_ready = 1'b1;
        in_data = 32'h44332211; in_valid = 4'hF; in_last = 4'hF;
        mode3 = 1'b0; sel3 = 2'd0; in_data3 = '0; in_valid3 = '0; in_last3 = '0; out_ready3 = 1'b1;
        xz_pat = 8'bxxxx_zzzz;

        // reset with traffic present
        smp;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", {24'b0, out_data}, 32'h0);
        chk("rst_out_last", {31'b0, out_last}, 32'd0);
        chk("rst_out_ch", {30'b0, out_ch}, 32'd0);
        chk("rst_in_ready", {28'b0, in_ready}, 32'h0);

        nxt; rst = 1'b0; in_valid = 4'b0001; in_last = 4'b0001; in_data[7:0] = 8'hA5;
        smp; chk("first_in_ready", {28'b0, in_ready}, 32'h1);
        nxt; in_valid = 4'b0000;
        smp;
        chk("first_valid", {31'b0, out_valid}, 32'd1);
        chk("first_data", {24'b0, out_data}, 32'hA5);
        chk("first_ch", {30'b0, out_ch}, 32'd0);
        chk("first_last", {31'b0, out_last}, 32'd1);
        nxt; smp; chk("drain_valid", {31'b0, out_valid}, 32'd0);

        // fixed select
        nxt; in_data = 32'h44332211; in_valid = 4'hF; in_last = 4'hF; sel = 2'd2;
        smp; chk("fix_ready_s2", {28'b0, in_ready}, 32'h4);
        nxt; smp;
        chk("fix_data_s2", {24'b0, out_data}, 32'h33);
        chk("fix_ch_s2", {30'b0, out_ch}, 32'd2);
        nxt; sel = 2'd1;
        smp;
        chk("fix_data_s2b", {24'b0, out_data}, 32'h33);
        chk("fix_ready_s1", {28'b0, in_ready}, 32'h2);
        nxt; sel = 2'd3;
        smp;
        chk("fix_data_s1", {24'b0, out_data}, 32'h22);
        chk("fix_ch_s1", {30'b0, out_ch}, 32'd1);
        nxt; mode = 1'b1;
        smp;
        chk("fix_data_s3", {24'b0, out_data}, 32'h44);
        chk("rr_ready_p0", {28'b0, in_ready}, 32'h1);

        // round-robin, all valid: 0,1,2,3,0
        nxt; smp; chk("rr_seq0", {30'b0, out_ch}, 32'd0);
        nxt; smp; chk("rr_seq1", {30'b0, out_ch}, 32'd1);
        nxt; smp; chk("rr_seq2", {30'b0, out_ch}, 32'd2);
        nxt; smp; chk("rr_seq3", {30'b0, out_ch}, 32'd3);
        nxt; in_valid = 4'b1101;
        smp; chk("rr_seq4", {30'b0, out_ch}, 32'd0);
        // ch1 dropped: 2,3,0,2
        nxt; smp; chk("rr_drop0", {30'b0, out_ch}, 32'd2);
        nxt; smp; chk("rr_drop1", {30'b0, out_ch}, 32'd3);
        nxt; smp; chk("rr_drop2", {30'b0, out_ch}, 32'd0);
        nxt; in_valid = 4'b0001;
        smp; chk("rr_drop3", {30'b0, out_ch}, 32'd2);

        // packet lock on ch1 with a two-cycle gap
        nxt; in_valid = 4'b0111; in_last = 4'b0101; in_data = 32'h0033B111;
        smp;
        chk("lk_pre_ch", {30'b0, out_ch}, 32'd0);
        chk("lk_ready_b1", {28'b0, in_ready}, 32'h2);
        nxt; in_valid = 4'b0101;
        smp;
        chk("lk_data_b1", {24'b0, out_data}, 32'hB1);
        chk("lk_ch_b1", {30'b0, out_ch}, 32'd1);
        chk("lk_gap1_ready", {28'b0, in_ready}, 32'h0);
        nxt; smp;
        chk("lk_gap2_valid", {31'b0, out_valid}, 32'd0);
        chk("lk_gap2_ready", {28'b0, in_ready}, 32'h0);
        nxt; in_valid = 4'b0111; in_data[15:8] = 8'hB2;
        smp; chk("lk_ready_b2", {28'b0, in_ready}, 32'h2);
        nxt; in_data[15:8] = 8'hB3; in_last = 4'b0111;
        smp;
        chk("lk_data_b2", {24'b0, out_data}, 32'hB2);
        chk("lk_ch_b2", {30'b0, out_ch}, 32'd1);
        nxt; smp;
        chk("lk_data_b3", {24'b0, out_data}, 32'hB3);
        chk("lk_last_b3", {31'b0, out_last}, 32'd1);
        chk("lk_next_ready", {28'b0, in_ready}, 32'h4);

        // backpressure for three cycles
        nxt; out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            smp;
            chk("bp_ch", {30'b0, out_ch}, 32'd2);
            chk("bp_data", {24'b0, out_data}, 32'h33);
            chk("bp_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_ready", {28'b0, in_ready}, 32'h0);
            nxt;
        end
        out_ready = 1'b1;
        smp;
        chk("bp_rel_ready", {28'b0, in_ready}, 32'h1);
        chk("bp_rel_data", {24'b0, out_data}, 32'h33);
        nxt; in_valid = 4'b0000;
        smp;
        chk("bp_next_ch", {30'b0, out_ch}, 32'd0);
        chk("bp_next_data", {24'b0, out_data}, 32'h11);
        nxt; smp;
        chk("bp_drained", {31'b0, out_valid}, 32'd0);
        chk("beat_count", n_out, n_in);

        // reset in the middle of a packet
        nxt; in_valid = 4'b0010; in_last = 4'b0000; in_data[15:8] = 8'hC1;
        smp; chk("mid_ready", {28'b0, in_ready}, 32'h2);
        nxt; rst = 1'b1; in_valid = 4'b0011;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_data", {24'b0, out_data}, 32'h0);
        chk("mid_rst_ready", {28'b0, in_ready}, 32'h0);
        nxt; rst = 1'b0; mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; in_last = 4'b0001;
        in_data[7:0] = 8'hA5;
        smp; chk("post_rst_ready", {28'b0, in_ready}, 32'h1);
        nxt; smp;
        chk("post_rst_data", {24'b0, out_data}, 32'hA5);
        chk("post_rst_ch", {30'b0, out_ch}, 32'd0);

        // X/Z passthrough on the selected channel
        nxt; in_valid = 4'b0011; in_last = 4'b0011; in_data[7:0] = xz_pat; in_data[15:8] = 8'hFF;
        smp; chk("xz_ready", {28'b0, in_ready}, 32'h1);
        nxt; smp; chk("xz_data", {24'b0, out_data}, {24'b0, xz_pat});

        // three-channel instance, select out of range
        nxt; in_valid = 4'b0000; in_valid3 = 3'b111; in_last3 = 3'b111; in_data3 = 24'h333231;
        smp; chk("n3_ready_s0", {29'b0, in_ready3}, 32'h1);
        nxt; sel3 = 2'd3;
        smp;
        chk("n3_data", {24'b0, out_data3}, 32'h31);
        chk("n3_ch", {30'b0, out_ch3}, 32'd0);
        chk("n3_last", {31'b0, out_last3}, 32'd1);
        chk("n3_ready_s3", {29'b0, in_ready3}, 32'h0);
        nxt; smp; chk("n3_valid_drop", {31'b0, out_valid3}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel, W-bit registered stream multiplexer; successor to the 4:1 single-bit combinational muxes.
- Adds valid/ready handshakes on every input and the output, a fixed-select or round-robin arbitration mode, and packet locking via per-channel last flags.
- Sits between multiple producer streams and one consumer.
- Provides a single output register stage with full throughput.

Parameters:
- N_CH, 4, number of input channels (>=1).
- DATA_W, 8, data width per channel.
- SEL_W, (N_CH>1 ? $clog2(N_CH) : 1), width of select and channel-ID fields.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- mode  in  1  0 = fixed select (sel), 1 = round-robin.
- sel  in  SEL_W  channel selected in fixed mode.
- in_data  in  N_CH*DATA_W  packed channel data; channel i occupies [i*DATA_W +: DATA_W].
- in_valid  in  N_CH  per-channel valid.
- in_last  in  N_CH  per-channel end-of-packet flag.
- in_ready  out  N_CH  per-channel ready; at most one bit high.
- out_data  out  DATA_W  registered data.
- out_last  out  1  registered last.
- out_ch  out  SEL_W  source channel of the current output beat.
- out_valid  out  1  output valid.
- out_ready  in  1  consumer ready.

Behaviour:
- Reset values (async, immediate):
  - out_valid=0, out_data=0, out_last=0, out_ch=0.
  - state=ARB, rr_ptr=0, lock_ch=0.
  - in_ready=0 while rst is high.
- Definitions:
  - load_en = !out_valid || out_ready.
  - A beat on channel i is accepted when in_valid[i] && in_ready[i].
- in_ready[i] = load_en && grant_valid && grant==i. It is combinational from in_valid/mode/sel/state.
- Accepted beat: on the next edge, out_data/out_last/out_ch take the granted channel's data, last and index, and out_valid=1. Latency is 1 cycle.
- If load_en && !grant_valid: out_valid clears on the edge (the previous beat was consumed). Otherwise the output register holds.
- Throughput: 1 beat/cycle when out_ready is held high. No combinational path from out_ready to out_data.
- Data is copied bit-exact: X/Z on the selected channel propagate to out_data. Non-selected channels never affect the output.
- Grant, state ARB:
  - mode=0: grant=sel, grant_valid=in_valid[sel]. If sel>=N_CH, grant_valid=0.
  - mode=1: first channel with in_valid set, searching rr_ptr, rr_ptr+1, … N_CH-1, 0, … rr_ptr-1 (wraps).
- Grant, state LOCK: grant=lock_ch, grant_valid=in_valid[lock_ch]. mode and sel are ignored.
- FSM (2 states):
  - ARB: accepted beat with in_last=0 -> LOCK, lock_ch=grant. Accepted beat with in_last=1 -> stay in ARB.
  - LOCK: accepted beat with in_last=1 -> ARB. Otherwise stay in LOCK; valid gaps on lock_ch are allowed and other channels stay blocked.
- rr_ptr updates only when a beat with in_last=1 is accepted: rr_ptr = (grant==N_CH-1) ? 0 : grant+1. It updates in both modes.
- Boundary cases:
  - mode or sel change mid-packet: no effect until the next ARB decision.
  - All in_valid low: no grant, and out_valid drains normally.
  - N_CH=1: channel 0 always; rr_ptr is constant 0.
  - out_ready low with out_valid=1: output held stable and all in_ready=0 (backpressure).
  - Reset mid-packet: partial packet and buffered beat are discarded; FSM returns to ARB.

Decomposition:
- Package stream_mux_pkg:
  - state encoding ST_ARB=1'b0, ST_LOCK=1'b1.
  - MODE_FIXED=1'b0, MODE_RR=1'b1.
- Sub-module rr_arbiter: combinational, parametrised by N_CH.
  - Inputs: req[N_CH], ptr[SEL_W].
  - Outputs: gnt_idx[SEL_W], gnt_valid. Rotate-priority search.
- Top level holds the FSM, rr_ptr, lock_ch, the output register and the fixed/RR mux.

Test Plan (N_CH=4, DATA_W=8):
- Reset during traffic; release -> all outputs 0 and in_ready=0 during reset. After release, a beat on ch0 with mode=0, sel=0, data 8'hA5, last=1 -> out_data=A5, out_ch=0, out_valid=1 one cycle later.
- Fixed mode, sel=2, all valid, data {ch3..0}=44,33,22,11, last=1, out_ready=1 -> every cycle out_data=8'h33, out_ch=2; in_ready=4'b0100. Then sel=3'd? not applicable; set sel=1 -> next beat 8'h22.
- Round-robin: all 4 channels valid with single-beat packets (last=1), out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles; then drop ch1 valid -> sequence 2,3,0,2.
- Packet lock: RR mode, ch1 sends 3 beats (last on the 3rd) with a 2-cycle valid gap after beat 1, ch0/ch2 valid throughout -> out_ch=1 for all 3 beats and no ch0/ch2 beat interleaves. The next grant is ch2.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data/out_ch stable and in_ready=0000. When out_ready returns to 1 the next beat loads the same cycle, and no beat is lost or duplicated (scoreboard count matches).
- X/Z passthrough: mode=0, sel=0, in ch0 data=8'bxxxx_zzzz, ch1 valid data 8'hFF -> out_data === 8'bxxxx_zzzz. Out-of-range is impossible at N_CH=4, so rerun with N_CH=3 and sel=3 -> in_ready=000 and out_valid deasserts.
